// File: rtl/line_fifo_mc_pkg.sv
// -----------------------------------------------------------------------------
// line_fifo_mc_pkg
// Shared constants and helpers for the multi-channel line buffer.
//   DEF_DATA_WIDTH / DEF_DEPTH / DEF_NUM_CH : default geometry of the buffer
//   ptr_inc()                               : modulo-DEPTH pointer increment
// -----------------------------------------------------------------------------
package line_fifo_mc_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 4608;
   localparam int DEF_NUM_CH     = 4;

   // DEPTH need not be a power of two, so the wrap is an explicit compare
   // against DEPTH-1 rather than relying on the pointer rolling over.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                           input logic [31:0] depth);
      if (ptr == depth - 32'd1) begin
         return 32'd0;
      end
      return ptr + 32'd1;
   endfunction

endpackage

// File: rtl/line_fifo_mc_fifo_ram_sdp.sv
// -----------------------------------------------------------------------------
// fifo_ram_sdp
// Simple dual-port RAM for one channel of the line buffer: one write port and
// one registered read port, written so that block RAM is inferred.
//   clk_i   : clock
//   we_i    : write enable, wdata_i stored at waddr_i
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable, rdata_o loads mem[raddr_i] on the next edge
//   raddr_i : read address
//   rdata_o : registered read data (holds when re_i is low)
// -----------------------------------------------------------------------------
module fifo_ram_sdp #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // No reset on the array or the output register so the tools can map both
   // onto a block RAM primitive.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/line_fifo_mc.sv
// -----------------------------------------------------------------------------
// line_fifo_mc
// Multi-channel lock-step line buffer between the input loader and the PE
// array. NUM_CH channels share one write/read/mark pointer set. A mark/rewind
// mechanism lets the row engine re-read a retained window.
//   clk, rst_n (async, active-low), clr (sync clear of pointers/counts/errors)
//   wr_en, wr_data         : write side, channel c in [c*DATA_WIDTH +: DATA_WIDTH]
//   full, almost_full      : occupancy flags (occ_count based)
//   rd_en, rd_data, rd_valid : read side, one-cycle latency, data zero when idle
//   empty                  : rd_count == 0
//   keep, rewind           : retain consumed words from the mark / return to it
//   rd_count, occ_count    : unread words / retained plus unread words
//   ovf, udf               : sticky overflow / underflow
// -----------------------------------------------------------------------------
module line_fifo_mc
   import line_fifo_mc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int AF_LEVEL   = DEPTH - 16,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
   output logic                         full,
   output logic                         almost_full,
   input  logic                         rd_en,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
   output logic                         rd_valid,
   output logic                         empty,
   input  logic                         keep,
   input  logic                         rewind,
   output logic [CW-1:0]                rd_count,
   output logic [CW-1:0]                occ_count,
   output logic                         ovf,
   output logic                         udf
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] mark_ptr_q, mark_ptr_d;
   logic [CW-1:0] rd_count_q, rd_count_d;
   logic [CW-1:0] occ_count_q, occ_count_d;
   logic          full_q, full_d;
   logic          af_q, af_d;
   logic          empty_q, empty_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          rd_valid_q, rd_valid_d;

   logic          wr_acc;
   logic          rd_acc;
   logic          rewind_do;
   logic [PW-1:0] wr_ptr_inc;
   logic [PW-1:0] rd_ptr_inc;

   logic [NUM_CH*DATA_WIDTH-1:0] ram_rdata;

   assign wr_ptr_inc = PW'(ptr_inc(32'(wr_ptr_q), 32'(DEPTH)));
   assign rd_ptr_inc = PW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH)));

   // Acceptance uses the registered flags only: no fall-through into an empty
   // buffer, and a read does not make room for a same-cycle write.
   assign wr_acc    = wr_en & ~full_q & ~clr;
   assign rd_acc    = rd_en & ~empty_q & ~rewind & ~clr;
   assign rewind_do = rewind & keep & ~clr;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mark_ptr_d  = mark_ptr_q;
      rd_count_d  = rd_count_q;
      occ_count_d = occ_count_q;
      ovf_d       = ovf_q;
      udf_d       = udf_q;

      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         mark_ptr_d  = '0;
         rd_count_d  = '0;
         occ_count_d = '0;
         ovf_d       = 1'b0;
         udf_d       = 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_inc;
         end

         if (rewind_do) begin
            // Everything from the mark onward becomes unread again.
            rd_ptr_d   = mark_ptr_q;
            rd_count_d = occ_count_q + CW'(wr_acc);
         end else begin
            if (rd_acc) begin
               rd_ptr_d = rd_ptr_inc;
            end
            rd_count_d = rd_count_q + CW'(wr_acc) - CW'(rd_acc);
         end

         if (keep) begin
            occ_count_d = occ_count_q + CW'(wr_acc);
         end else begin
            // Mark follows the read pointer, so nothing is retained.
            mark_ptr_d  = rd_ptr_d;
            occ_count_d = rd_count_d;
         end

         ovf_d = ovf_q | (wr_en & full_q);
         udf_d = udf_q | (rd_en & empty_q & ~rewind);
      end

      rd_valid_d = rd_acc;
      full_d     = (occ_count_d == CW'(DEPTH));
      af_d       = (occ_count_d >= CW'(AF_LEVEL));
      empty_d    = (rd_count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mark_ptr_q  <= '0;
         rd_count_q  <= '0;
         occ_count_q <= '0;
         full_q      <= 1'b0;
         af_q        <= 1'b0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mark_ptr_q  <= mark_ptr_d;
         rd_count_q  <= rd_count_d;
         occ_count_q <= occ_count_d;
         full_q      <= full_d;
         af_q        <= af_d;
         empty_q     <= empty_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      fifo_ram_sdp #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_ram (
         .clk_i   (clk),
         .we_i    (wr_acc),
         .waddr_i (wr_ptr_q),
         .wdata_i (wr_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .re_i    (rd_acc),
         .raddr_i (rd_ptr_q),
         .rdata_o (ram_rdata[c*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // The RAM output register has no reset; gating with the async-reset valid
   // bit makes rd_data drop to zero immediately on reset and when idle.
   assign rd_data     = rd_valid_q ? ram_rdata : '0;
   assign rd_valid    = rd_valid_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign empty       = empty_q;
   assign rd_count    = rd_count_q;
   assign occ_count   = occ_count_q;
   assign ovf         = ovf_q;
   assign udf         = udf_q;

   // Counter ordering invariant: 0 <= rd_count <= occ_count <= DEPTH.
   property p_count_order;
      @(posedge clk) disable iff (!rst_n)
         (rd_count_q <= occ_count_q) && (occ_count_q <= CW'(DEPTH));
   endproperty
   a_count_order: assert property (p_count_order);

endmodule

// File: tb/tb_line_fifo_mc.sv
module tb_line_fifo_mc;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int NCH   = 2;
   localparam int AFL   = 6;
   localparam int CW    = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst_n;
   logic              clr;
   logic              wr_en;
   logic [NCH*DW-1:0] wr_data;
   logic              full;
   logic              almost_full;
   logic              rd_en;
   logic [NCH*DW-1:0] rd_data;
   logic              rd_valid;
   logic              empty;
   logic              keep;
   logic              rewind;
   logic [CW-1:0]     rd_count;
   logic [CW-1:0]     occ_count;
   logic              ovf;
   logic              udf;

   int n_tests = 0;
   int n_fail  = 0;

   line_fifo_mc #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .NUM_CH     (NCH),
      .AF_LEVEL   (AFL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .almost_full (almost_full),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .empty       (empty),
      .keep        (keep),
      .rewind      (rewind),
      .rd_count    (rd_count),
      .occ_count   (occ_count),
      .ovf         (ovf),
      .udf         (udf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_word(input logic [15:0] c0, input logic [15:0] c1);
      wr_en   = 1'b1;
      wr_data = {c1, c0};
      step();
      wr_en   = 1'b0;
   endtask

   task automatic rd_word(input string tag, input logic [15:0] c0, input logic [15:0] c1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_data"}, rd_data, {c1, c0});
   endtask

   initial begin
      rst_n   = 1'b0;
      clr     = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      keep    = 1'b0;
      rewind  = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_rd_count", 32'(rd_count), 32'd0);
      chk("rst_occ", 32'(occ_count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_af", 32'(almost_full), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_data", rd_data, 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_udf", 32'(udf), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic write 3 / read 3
      wr_word(16'h0011, 16'h1011);
      wr_word(16'h0022, 16'h1022);
      wr_word(16'h0033, 16'h1033);
      chk("basic_cnt3", 32'(rd_count), 32'd3);
      chk("basic_occ3", 32'(occ_count), 32'd3);
      chk("basic_nempty", 32'(empty), 32'd0);
      rd_word("basic_r1", 16'h0011, 16'h1011);
      chk("basic_cnt2", 32'(rd_count), 32'd2);
      rd_word("basic_r2", 16'h0022, 16'h1022);
      chk("basic_cnt1", 32'(rd_count), 32'd1);
      rd_word("basic_r3", 16'h0033, 16'h1033);
      chk("basic_cnt0", 32'(rd_count), 32'd0);
      chk("basic_empty", 32'(empty), 32'd1);
      step();
      chk("basic_idle_valid", 32'(rd_valid), 32'd0);
      chk("basic_idle_data", rd_data, 32'd0);

      // Full / overflow: 9 writes, 9th dropped
      for (int k = 1; k <= 9; k++) begin
         wr_word(16'h0100 + 16'(k), 16'h0200 + 16'(k));
         if (k == 5) chk("full_af_at5", 32'(almost_full), 32'd0);
         if (k == 6) chk("full_af_at6", 32'(almost_full), 32'd1);
         if (k == 7) chk("full_full_at7", 32'(full), 32'd0);
         if (k == 8) chk("full_full_at8", 32'(full), 32'd1);
      end
      chk("full_ovf", 32'(ovf), 32'd1);
      chk("full_occ8", 32'(occ_count), 32'd8);
      chk("full_cnt8", 32'(rd_count), 32'd8);
      for (int k = 1; k <= 8; k++) begin
         rd_word("full_rd", 16'h0100 + 16'(k), 16'h0200 + 16'(k));
      end
      chk("full_empty", 32'(empty), 32'd1);
      chk("full_nfull", 32'(full), 32'd0);

      // Wrap: two batches of 6 across the pointer wrap
      for (int b = 0; b < 2; b++) begin
         for (int k = 1; k <= 6; k++) begin
            wr_word(16'h0300 + 16'(b * 16 + k), 16'h1300 + 16'(b * 16 + k));
         end
         chk("wrap_cnt6", 32'(rd_count), 32'd6);
         for (int k = 1; k <= 6; k++) begin
            rd_word("wrap_rd", 16'h0300 + 16'(b * 16 + k), 16'h1300 + 16'(b * 16 + k));
         end
      end
      chk("wrap_empty", 32'(empty), 32'd1);
      chk("wrap_udf", 32'(udf), 32'd0);

      // Rewind: keep, write A..D, read 4, rewind with rd_en, reread
      keep = 1'b1;
      for (int k = 1; k <= 4; k++) wr_word(16'h00A0 + 16'(k), 16'h10A0 + 16'(k));
      for (int k = 1; k <= 4; k++) rd_word("rew_rd", 16'h00A0 + 16'(k), 16'h10A0 + 16'(k));
      chk("rew_empty", 32'(empty), 32'd1);
      chk("rew_occ4", 32'(occ_count), 32'd4);
      chk("rew_cnt0", 32'(rd_count), 32'd0);
      rewind = 1'b1;
      rd_en  = 1'b1;
      step();
      rewind = 1'b0;
      rd_en  = 1'b0;
      chk("rew_cnt4", 32'(rd_count), 32'd4);
      chk("rew_occ_hold", 32'(occ_count), 32'd4);
      chk("rew_no_valid", 32'(rd_valid), 32'd0);
      chk("rew_udf", 32'(udf), 32'd0);
      for (int k = 1; k <= 4; k++) rd_word("rew_reread", 16'h00A0 + 16'(k), 16'h10A0 + 16'(k));
      chk("rew_empty2", 32'(empty), 32'd1);
      keep = 1'b0;
      step();
      chk("rew_release_occ", 32'(occ_count), 32'd0);

      // Retention blocks writes
      keep = 1'b1;
      for (int k = 1; k <= 8; k++) wr_word(16'h0500 + 16'(k), 16'h1500 + 16'(k));
      for (int k = 1; k <= 3; k++) rd_word("ret_rd", 16'h0500 + 16'(k), 16'h1500 + 16'(k));
      chk("ret_cnt5", 32'(rd_count), 32'd5);
      chk("ret_full", 32'(full), 32'd1);
      wr_word(16'hDEAD, 16'hBEEF);
      chk("ret_wr_rej_cnt", 32'(rd_count), 32'd5);
      chk("ret_wr_rej_occ", 32'(occ_count), 32'd8);
      keep = 1'b0;
      step();
      chk("ret_drop_occ5", 32'(occ_count), 32'd5);
      chk("ret_drop_nfull", 32'(full), 32'd0);
      chk("ret_drop_af", 32'(almost_full), 32'd0);
      wr_word(16'h0509, 16'h1509);
      chk("ret_wr_cnt6", 32'(rd_count), 32'd6);
      chk("ret_wr_af", 32'(almost_full), 32'd1);
      rd_word("ret_rd4", 16'h0504, 16'h1504);
      chk("ret_cnt5b", 32'(rd_count), 32'd5);

      // Clear with concurrent write
      chk("clr_pre_ovf", 32'(ovf), 32'd1);
      clr     = 1'b1;
      wr_en   = 1'b1;
      wr_data = 32'h1234_5678;
      step();
      clr   = 1'b0;
      wr_en = 1'b0;
      chk("clr_cnt", 32'(rd_count), 32'd0);
      chk("clr_occ", 32'(occ_count), 32'd0);
      chk("clr_ovf", 32'(ovf), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_valid", 32'(rd_valid), 32'd0);

      // Underflow on empty read
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("udf_set", 32'(udf), 32'd1);
      chk("udf_no_valid", 32'(rd_valid), 32'd0);

      // Async reset in the middle of a read
      wr_word(16'h0777, 16'h1777);
      rd_en = 1'b1;
      step();
      chk("arst_pre_valid", 32'(rd_valid), 32'd1);
      chk("arst_pre_data", rd_data, 32'h1777_0777);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(rd_valid), 32'd0);
      chk("arst_data", rd_data, 32'd0);
      chk("arst_udf", 32'(udf), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      rd_en = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
